// File: rtl/tpu_csr_pkg.sv
// Shared constants for the TPU Avalon-MM CSR slave: register map, bit indices,
// FIFO widths and a level-to-byte helper used by the STATUS register.
package tpu_csr_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_OPA    = 3'd2;
  localparam logic [2:0] ADDR_OPB    = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_ID     = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_RES_AVAIL = 1;
  localparam int ST_UNDERFLOW = 4;
  localparam int ST_ERR       = 5;

  localparam logic [31:0] CORE_ID_DEFAULT = 32'h5450_0001;

  localparam int DATA_W = 32;
  localparam int OP_W   = 33;
  localparam int RES_W  = 32;

  // A 256-deep FIFO has a 9-bit level; saturate so a full FIFO never reads as empty.
  function automatic logic [7:0] level_sat8(input logic [8:0] lvl);
    if (lvl > 9'd255) begin
      return 8'hFF;
    end else begin
      return lvl[7:0];
    end
  endfunction

endpackage

// File: rtl/tpu_sync_fifo.sv
// Single-clock FIFO with guarded push/pop, synchronous flush and an occupancy level.
// A push while full is refused even if a pop happens in the same cycle.
module tpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_MAX);
  assign empty  = (r_count == {(AW+1){1'b0}});
  assign level  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/tpu_avmm_csr_slave.sv
// Avalon-MM CSR slave bridging HPS register accesses to the TPU operand/result streams.
// Optional interrupt output enabled by defining TPU_CSR_IRQ_EN.
module tpu_avmm_csr_slave
  import tpu_csr_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] CORE_ID    = CORE_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_sel,
  output logic [31:0] op_data,
  output logic        op_start,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data
`ifdef TPU_CSR_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            w_op_full, w_op_empty, w_res_full, w_res_empty;
  logic [LW-1:0]   w_op_level, w_res_level;
  logic [OP_W-1:0] w_op_din, w_op_dout;
  logic [RES_W-1:0] w_res_dout;
  logic            w_is_op_addr, w_be_full;
  logic            w_wr_acc, w_rd_acc;
  logic            w_op_push, w_op_pop, w_op_wr_bad;
  logic            w_res_push, w_res_rd, w_res_pop;
  logic            w_ctrl_wr, w_status_wr, w_flush;
  logic            w_underflow_set, w_err_set;
  logic [31:0]     w_status, w_rd_mux;

  logic            r_irq_en, r_underflow, r_err, r_op_start, r_readdatavalid;
  logic [31:0]     r_readdata;

  assign w_is_op_addr    = (avs_address == ADDR_OPA) || (avs_address == ADDR_OPB);
  assign w_be_full       = (avs_byteenable == 4'hF);
  assign avs_waitrequest = avs_write & w_is_op_addr & w_op_full;
  assign w_wr_acc        = avs_write & ~avs_waitrequest;
  // A concurrent read and write is illegal; the write is served and the read dropped.
  assign w_rd_acc        = avs_read & ~avs_write;

  assign w_op_push   = w_wr_acc & w_is_op_addr & w_be_full;
  assign w_op_wr_bad = w_wr_acc & w_is_op_addr & ~w_be_full;
  assign w_op_din    = {(avs_address == ADDR_OPB), avs_writedata};
  assign w_op_pop    = ~w_op_empty & op_ready;

  assign w_ctrl_wr   = w_wr_acc & (avs_address == ADDR_CTRL) & avs_byteenable[0];
  assign w_status_wr = w_wr_acc & (avs_address == ADDR_STATUS) & avs_byteenable[0];
  assign w_flush     = w_ctrl_wr & avs_writedata[CTRL_FLUSH];

  assign w_res_push      = res_valid & ~w_res_full;
  assign w_res_rd        = w_rd_acc & (avs_address == ADDR_RESULT);
  assign w_res_pop       = w_res_rd & ~w_res_empty;
  assign w_underflow_set = w_res_rd & w_res_empty;
  assign w_err_set       = w_op_wr_bad | (avs_read & avs_write);

  tpu_sync_fifo #(.WIDTH(OP_W), .DEPTH(FIFO_DEPTH)) u_op_fifo (
    .clk(clk), .reset_n(reset_n), .flush(w_flush),
    .push(w_op_push), .pop(w_op_pop), .din(w_op_din), .dout(w_op_dout),
    .full(w_op_full), .empty(w_op_empty), .level(w_op_level)
  );

  tpu_sync_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk(clk), .reset_n(reset_n), .flush(w_flush),
    .push(w_res_push), .pop(w_res_pop), .din(res_data), .dout(w_res_dout),
    .full(w_res_full), .empty(w_res_empty), .level(w_res_level)
  );

  always_comb begin
    w_status               = 32'd0;
    w_status[ST_BUSY]      = ~w_op_empty;
    w_status[ST_RES_AVAIL] = ~w_res_empty;
    w_status[ST_UNDERFLOW] = r_underflow;
    w_status[ST_ERR]       = r_err;
    w_status[15:8]         = level_sat8(9'(w_op_level));
    w_status[23:16]        = level_sat8(9'(w_res_level));
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (avs_address)
      ADDR_CTRL:   w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_RESULT: w_rd_mux = w_res_empty ? 32'd0 : w_res_dout;
      ADDR_ID:     w_rd_mux = CORE_ID;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Sticky bits: a set in the same cycle as a W1C clear takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata      <= 32'd0;
      r_readdatavalid <= 1'b0;
      r_op_start      <= 1'b0;
      r_irq_en        <= 1'b0;
      r_underflow     <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_readdatavalid <= w_rd_acc;
      if (w_rd_acc) r_readdata <= w_rd_mux;
      r_op_start <= w_ctrl_wr & avs_writedata[CTRL_START];
      if (w_ctrl_wr) r_irq_en <= avs_writedata[CTRL_IRQ_EN];
      if (w_underflow_set) r_underflow <= 1'b1;
      else if (w_status_wr && avs_writedata[ST_UNDERFLOW]) r_underflow <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
      else if (w_status_wr && avs_writedata[ST_ERR]) r_err <= 1'b0;
    end
  end

`ifdef TPU_CSR_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_irq_en & (~w_res_empty | r_underflow | r_err);
  end

  assign irq = r_irq;
`endif

  assign avs_readdata      = r_readdata;
  assign avs_readdatavalid = r_readdatavalid;
  assign op_valid          = ~w_op_empty;
  assign op_sel            = w_op_dout[OP_W-1];
  assign op_data           = w_op_dout[DATA_W-1:0];
  assign op_start          = r_op_start;
  assign res_ready         = ~w_res_full;

endmodule

// File: tb/tb_tpu_avmm_csr_slave.sv
// Scoreboard bench for tpu_avmm_csr_slave: read responses and operand words are
// predicted into queues at stimulus time and compared when the DUT emits them.
module tb_tpu_avmm_csr_slave;
  import tpu_csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [3:0]  avs_byteenable = 4'h0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest;
  logic        op_valid, op_sel, op_start, res_ready;
  logic        op_ready = 1'b0;
  logic [31:0] op_data;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = 32'd0;
`ifdef TPU_CSR_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_q [$];
  logic [32:0] op_q [$];

  tpu_avmm_csr_slave dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .op_valid(op_valid), .op_ready(op_ready),
    .op_sel(op_sel), .op_data(op_data), .op_start(op_start), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
`ifdef TPU_CSR_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read-response scoreboard
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      check_eq("rd_expected", rd_q.size() != 0, 1'b1);
      if (rd_q.size() != 0) check_eq("rdata", avs_readdata, rd_q.pop_front());
    end
  end

  // Operand-stream scoreboard
  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      check_eq("op_expected", op_q.size() != 0, 1'b1);
      if (op_q.size() != 0) check_eq("op_word", {op_sel, op_data}, op_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic avm_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    if (((a == ADDR_OPA) || (a == ADDR_OPB)) && (be == 4'hF)) op_q.push_back({a == ADDR_OPB, d});
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("wr_timeout", avs_waitrequest, 1'b0);
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic avm_read(input logic [2:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic res_push(input logic [31:0] d);
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = d;
    @(negedge clk);
    check_eq("res_ready", res_ready, 1'b1);
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    check_eq("rst_rdv", avs_readdatavalid, 1'b0);
    check_eq("rst_rdata", avs_readdata, 32'd0);
    check_eq("rst_opv", op_valid, 1'b0);
    check_eq("rst_start", op_start, 1'b0);
`ifdef TPU_CSR_IRQ_EN
    check_eq("rst_irq", irq, 1'b0);
`endif
    @(posedge clk); #1 reset_n = 1'b1;

    avm_read(ADDR_ID, 32'h5450_0001);
    avm_read(ADDR_STATUS, 32'h0);

    // Two operands held back, then released in order
    avm_write(ADDR_OPA, 32'h11, 4'hF);
    avm_write(ADDR_OPB, 32'h22, 4'hF);
    avm_read(ADDR_STATUS, 32'h0000_0201);
    op_ready = 1'b1;
    cyc(4);
    op_ready = 1'b0;
    check_eq("op_drained", op_q.size(), 0);
    avm_read(ADDR_STATUS, 32'h0);

    // Fill the operand FIFO and stall the 17th write
    for (int i = 0; i < 16; i++) avm_write(ADDR_OPA, 32'h100 + i, 4'hF);
    avm_read(ADDR_STATUS, 32'h0000_1001);
    @(posedge clk); #1;
    avs_address = ADDR_OPA; avs_writedata = 32'h1FF; avs_byteenable = 4'hF; avs_write = 1'b1;
    op_q.push_back({1'b0, 32'h1FF});
    @(negedge clk);
    check_eq("wait_full", avs_waitrequest, 1'b1);
    @(posedge clk); #1 op_ready = 1'b1;
    @(negedge clk);
    check_eq("wait_nobypass", avs_waitrequest, 1'b1);
    @(posedge clk); #1 op_ready = 1'b0;
    @(negedge clk);
    check_eq("wait_freed", avs_waitrequest, 1'b0);
    @(posedge clk); #1 avs_write = 1'b0;
    avm_read(ADDR_STATUS, 32'h0000_1001);
    op_ready = 1'b1;
    cyc(20);
    op_ready = 1'b0;
    check_eq("op_drained2", op_q.size(), 0);

    // Result path and underflow
    res_push(32'hA5);
    res_push(32'h5A);
    avm_read(ADDR_STATUS, 32'h0002_0002);
    avm_read(ADDR_RESULT, 32'hA5);
    avm_read(ADDR_RESULT, 32'h5A);
    avm_read(ADDR_RESULT, 32'h0);
    avm_read(ADDR_STATUS, 32'h0000_0010);
    avm_write(ADDR_STATUS, 32'h10, 4'hF);
    avm_read(ADDR_STATUS, 32'h0);

    // Start pulse width
    avm_write(ADDR_CTRL, 32'h1, 4'hF);
    @(negedge clk);
    check_eq("start_hi", op_start, 1'b1);
    @(negedge clk);
    check_eq("start_lo", op_start, 1'b0);

    // Flush both FIFOs
    for (int i = 0; i < 3; i++) avm_write(ADDR_OPA, 32'h200 + i, 4'hF);
    res_push(32'h33);
    avm_read(ADDR_STATUS, 32'h0001_0303);
    avm_write(ADDR_CTRL, 32'h2, 4'hF);
    op_q.delete();
    @(negedge clk);
    check_eq("flush_opv", op_valid, 1'b0);
    avm_read(ADDR_STATUS, 32'h0);

    // Partial byteenable on an operand push
    avm_write(ADDR_OPA, 32'hDEAD, 4'h3);
    @(negedge clk);
    check_eq("be_nopush", op_valid, 1'b0);
    avm_read(ADDR_STATUS, 32'h0000_0020);
    avm_write(ADDR_STATUS, 32'h20, 4'hF);
    avm_read(ADDR_STATUS, 32'h0);

    // Illegal simultaneous read and write
    @(posedge clk); #1;
    avs_address = ADDR_CTRL; avs_writedata = 32'h0; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
    @(negedge clk);
    check_eq("rw_no_rsp", avs_readdatavalid, 1'b0);
    avm_read(ADDR_STATUS, 32'h0000_0020);
    avm_write(ADDR_STATUS, 32'h20, 4'hF);

    // Unmapped addresses and CTRL readback
    avm_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    avm_read(3'd6, 32'h0);
    avm_read(3'd7, 32'h0);
    avm_write(ADDR_CTRL, 32'h4, 4'hF);
    avm_read(ADDR_CTRL, 32'h4);
    avm_read(ADDR_STATUS, 32'h0);

`ifdef TPU_CSR_IRQ_EN
    res_push(32'h77);
    cyc(2);
    @(negedge clk);
    check_eq("irq_set", irq, 1'b1);
    @(posedge clk); #1;
    avs_address = ADDR_RESULT; avs_read = 1'b1;
    rd_q.push_back(32'h77);
    @(posedge clk); #1 avs_read = 1'b0;
    @(negedge clk);
    check_eq("irq_hold", irq, 1'b1);
    @(negedge clk);
    check_eq("irq_clear", irq, 1'b0);
`endif

    // Reset coinciding with a read request drops the response
    avm_write(ADDR_OPA, 32'h99, 4'hF);
    @(posedge clk); #1;
    avs_address = ADDR_ID; avs_read = 1'b1; reset_n = 1'b0;
    @(posedge clk); #1 avs_read = 1'b0;
    op_q.delete();
    @(negedge clk);
    check_eq("rst_rd_drop", avs_readdatavalid, 1'b0);
    check_eq("rst_op_empty", op_valid, 1'b0);
    @(negedge clk);
    check_eq("rst_rd_drop2", avs_readdatavalid, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    avm_read(ADDR_CTRL, 32'h0);
    avm_read(ADDR_STATUS, 32'h0);

    cyc(3);
    check_eq("rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
